// File: rtl/rc4_pkg.sv
`default_nettype none
// =============================================================================
// rc4_pkg : shared RC4 types and sizes (S-RAM geometry, KSA state encoding)
// Revision: 1.0
// =============================================================================
package rc4_pkg;

    localparam int RAM_DEPTH = 256;
    localparam int S_ADDR_W  = 8;

    typedef logic [7:0] s_byte_t;

    typedef enum logic [3:0] {
        KSA_IDLE  = 4'd0,
        KSA_RD_I  = 4'd1,
        KSA_WT_I  = 4'd2,
        KSA_CAP_I = 4'd3,
        KSA_RD_J  = 4'd4,
        KSA_WT_J  = 4'd5,
        KSA_CAP_J = 4'd6,
        KSA_WR_I  = 4'd7,
        KSA_WR_J  = 4'd8,
        KSA_DONE  = 4'd9
    } ksa_state_t;

endpackage : rc4_pkg
`default_nettype wire

// File: rtl/ksa_swapper_if.sv
`default_nettype none
// =============================================================================
// ksa_swapper_if : start/finished handshake, key and single-port S-RAM bus
// Revision: 1.0
// =============================================================================
interface ksa_swapper_if #(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = 8
) ();
    import rc4_pkg::*;

    logic                   start;
    logic [8*KEY_BYTES-1:0] secret_key;
    s_byte_t                ram_out;
    logic [ADDR_W-1:0]      address;
    s_byte_t                ram_in;
    logic                   write_enable;
    logic                   finished;

    // master = controller + RAM side, slave = the KSA engine
    modport master (
        output start, secret_key, ram_out,
        input  address, ram_in, write_enable, finished
    );

    modport slave (
        input  start, secret_key, ram_out,
        output address, ram_in, write_enable, finished
    );

endinterface : ksa_swapper_if
`default_nettype wire

// File: rtl/ksa_swapper_key_byte_select.sv
`default_nettype none
// =============================================================================
// key_byte_select : picks key byte kidx from an MSB-first packed secret key
// Revision: 1.0
// =============================================================================
module key_byte_select
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
    input  wire logic [8*KEY_BYTES-1:0] secret_key_i,
    input  wire logic [KIDX_W-1:0]      kidx_i,
    output s_byte_t                     key_byte_o
);

    always_comb begin
        key_byte_o = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx_i == KIDX_W'(b)) begin
                key_byte_o = secret_key_i[8*(KEY_BYTES-b)-1 -: 8];
            end
        end
    end

endmodule : key_byte_select
`default_nettype wire

// File: rtl/ksa_swapper.sv
`default_nettype none
// =============================================================================
// ksa_swapper : RC4 key-scheduling swap engine on a shared single-port S-RAM
// Option macro: KSA_SKIP_SELF_SWAP_EN (skip read/write of S[j] when j == i)
// Revision: 1.0
// =============================================================================
module ksa_swapper
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = S_ADDR_W
) (
    input  wire logic    clk,
    input  wire logic    reset,
    ksa_swapper_if.slave bus
);

    localparam int                KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

    ksa_state_t          state_q, state_d;
    s_byte_t             i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [KIDX_W-1:0]   kidx_q, kidx_d;

    s_byte_t             w_key_byte, w_j_sum, w_ram_in;
    logic [ADDR_W-1:0]   w_address;
    logic                w_we, w_finished;

    key_byte_select #(
        .KEY_BYTES (KEY_BYTES),
        .KIDX_W    (KIDX_W)
    ) u_key_sel (
        .secret_key_i (bus.secret_key),
        .kidx_i       (kidx_q),
        .key_byte_o   (w_key_byte)
    );

    assign w_j_sum = j_q + bus.ram_out + w_key_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= KSA_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        sj_d       = sj_q;
        kidx_d     = kidx_q;
        w_address  = '0;
        w_ram_in   = '0;
        w_we       = 1'b0;
        w_finished = 1'b0;

        case (state_q)
            KSA_IDLE: begin
                if (bus.start) begin
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = KSA_RD_I;
                end
            end
            KSA_RD_I: begin
                w_address = ADDR_W'(i_q);
                state_d   = KSA_WT_I;
            end
            KSA_WT_I: begin
                w_address = ADDR_W'(i_q);
                state_d   = KSA_CAP_I;
            end
            KSA_CAP_I: begin
                w_address = ADDR_W'(i_q);
                si_d      = bus.ram_out;
                j_d       = w_j_sum;
                state_d   = KSA_RD_J;
`ifdef KSA_SKIP_SELF_SWAP_EN
                // S[i] and S[j] are the same byte: nothing to swap
                if (w_j_sum == i_q) begin
                    if (i_q == 8'hFF) begin
                        state_d = KSA_DONE;
                    end else begin
                        i_d     = i_q + 8'd1;
                        kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                        state_d = KSA_RD_I;
                    end
                end
`endif
            end
            KSA_RD_J: begin
                w_address = ADDR_W'(j_q);
                state_d   = KSA_WT_J;
            end
            KSA_WT_J: begin
                w_address = ADDR_W'(j_q);
                state_d   = KSA_CAP_J;
            end
            KSA_CAP_J: begin
                w_address = ADDR_W'(j_q);
                sj_d      = bus.ram_out;
                state_d   = KSA_WR_I;
            end
            KSA_WR_I: begin
                w_address = ADDR_W'(i_q);
                w_ram_in  = sj_q;
                w_we      = 1'b1;
                state_d   = KSA_WR_J;
            end
            KSA_WR_J: begin
                w_address = ADDR_W'(j_q);
                w_ram_in  = si_q;
                w_we      = 1'b1;
                if (i_q == 8'hFF) begin
                    state_d = KSA_DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                    state_d = KSA_RD_I;
                end
            end
            KSA_DONE: begin
                w_finished = 1'b1;
                if (!bus.start) begin
                    state_d = KSA_IDLE;
                end
            end
            default: begin
                state_d = KSA_IDLE;
            end
        endcase
    end

    assign bus.address      = w_address;
    assign bus.ram_in       = w_ram_in;
    assign bus.write_enable = w_we;
    assign bus.finished     = w_finished;

endmodule : ksa_swapper
`default_nettype wire

// File: tb/tb_ksa_swapper.sv
`default_nettype none
// =============================================================================
// tb_ksa_swapper : directed vector bench for ksa_swapper with a 2-cycle S-RAM
// Revision: 1.0
// =============================================================================
module tb_ksa_swapper;
    import rc4_pkg::*;

    localparam int KEY_BYTES = 3;
    localparam int ADDR_W    = 8;

    typedef struct {
        logic [23:0] key;
        bit          do_init;
        bit          hold;
        int          hidx;
        logic [7:0]  ha0, hd0, ha1, hd1;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ksa_swapper_if #(.KEY_BYTES(KEY_BYTES), .ADDR_W(ADDR_W)) bus ();

    ksa_swapper #(.KEY_BYTES(KEY_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // S-RAM: address registered, data registered -> valid two cycles later
    s_byte_t     mem [256];
    logic [7:0]  addr_r;
    logic        init_req = 1'b0;
    logic        cap_en   = 1'b0;
    logic [15:0] wr_log [$];

    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (bus.write_enable === 1'b1) begin
            mem[bus.address] <= bus.ram_in;
        end
        addr_r      <= bus.address;
        bus.ram_out <= mem[addr_r];
        if (cap_en && bus.write_enable === 1'b1) wr_log.push_back({bus.address, bus.ram_in});
    end

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference KSA on the bench's own copy of S
    s_byte_t     ms [256];
    logic [15:0] exp_w [$];
    int          exp_cycles;

    task automatic model_run(input logic [23:0] key);
        logic [7:0]  j, kb, t;
        logic [23:0] sh;
        bit          skip;
        exp_w.delete();
        exp_cycles = 0;
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            sh   = key >> (8 * (2 - (i % 3)));
            kb   = sh[7:0];
            j    = j + ms[i] + kb;
            skip = 1'b0;
`ifdef KSA_SKIP_SELF_SWAP_EN
            skip = (j == 8'(i));
`endif
            if (skip) begin
                exp_cycles += 3;
            end else begin
                exp_cycles += 8;
                exp_w.push_back({8'(i), ms[j]});
                exp_w.push_back({j, ms[i]});
                t = ms[i]; ms[i] = ms[j]; ms[j] = t;
            end
        end
    endtask

    task automatic load_identity();
        @(negedge clk);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        for (int k = 0; k < 256; k++) ms[k] = 8'(k);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int          cnt, mism;
        bit          seen;
        logic [15:0] w0, w1;
        if (v.do_init) load_identity();
        model_run(v.key);
        @(negedge clk);
        wr_log.delete();
        cap_en         = 1'b1;
        bus.secret_key = v.key;
        bus.start      = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 5000) begin
            @(posedge clk); #1;
            cnt++;
            if (!v.hold && cnt == 100) bus.start = 1'b0;
            seen = (bus.finished === 1'b1);
        end
        check($sformatf("v%0d_cycles", n), 32'(cnt - 1), 32'(exp_cycles));
        if (v.hold) begin
            repeat (3) begin @(posedge clk); #1; end
            check($sformatf("v%0d_fin_hold", n), 32'(bus.finished), 32'd1);
            bus.start = 1'b0;
            @(posedge clk); #1;
            check($sformatf("v%0d_fin_drop", n), 32'(bus.finished), 32'd0);
        end else begin
            @(posedge clk); #1;
            check($sformatf("v%0d_fin_pulse", n), 32'(bus.finished), 32'd0);
        end
        cap_en = 1'b0;
        check($sformatf("v%0d_wr_count", n), 32'(wr_log.size()), 32'(exp_w.size()));
        mism = 0;
        for (int k = 0; k < wr_log.size() && k < exp_w.size(); k++)
            if (wr_log[k] !== exp_w[k]) mism++;
        check($sformatf("v%0d_wr_seq", n), 32'(mism), 32'd0);
        if (v.hidx >= 0) begin
            w0 = 16'hxxxx;
            w1 = 16'hxxxx;
            if (v.hidx < wr_log.size())     w0 = wr_log[v.hidx];
            if (v.hidx + 1 < wr_log.size()) w1 = wr_log[v.hidx + 1];
            check($sformatf("v%0d_hand_w0", n), 32'(w0), 32'({v.ha0, v.hd0}));
            check($sformatf("v%0d_hand_w1", n), 32'(w1), 32'({v.ha1, v.hd1}));
        end
        mism = 0;
        for (int k = 0; k < 256; k++)
            if (mem[k] !== ms[k]) mism++;
        check($sformatf("v%0d_final_S", n), 32'(mism), 32'd0);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{24'h035F3C, 1'b1, 1'b0, 0,  8'h00, 8'h03, 8'h03, 8'h00};
        vecs[1] = '{24'h010203, 1'b1, 1'b0, 6,  8'h03, 8'h09, 8'h09, 8'h00};
        vecs[2] = '{24'hFFFFFF, 1'b1, 1'b1, 0,  8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[3] = '{24'h035F3C, 1'b0, 1'b0, -1, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef KSA_SKIP_SELF_SWAP_EN
        vecs[4] = '{24'h000000, 1'b1, 1'b0, -1, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        vecs[4] = '{24'h000000, 1'b1, 1'b0, 0,  8'h00, 8'h00, 8'h00, 8'h00};
`endif

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.secret_key = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_address", 32'(bus.address), 32'd0);
        check("rst_we",      32'(bus.write_enable), 32'd0);
        check("rst_finished",32'(bus.finished), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Abort in RD_J of iteration 10 (cycle 8*10+3 after the start edge)
        load_identity();
        @(negedge clk);
        bus.secret_key = 24'h035F3C;
        bus.start      = 1'b1;
        repeat (84) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_address",  32'(bus.address), 32'd0);
        check("abort_we",       32'(bus.write_enable), 32'd0);
        check("abort_finished", 32'(bus.finished), 32'd0);
        @(posedge clk); #1;
        check("abort_next_we",      32'(bus.write_enable), 32'd0);
        check("abort_next_address", 32'(bus.address), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 5; n++) run_vec(vecs[n], n);

        // Zero key: i=0 yields j=0
        load_identity();
        @(negedge clk);
        bus.secret_key = 24'h000000;
        bus.start      = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("self_we_c%0d", c), 32'(bus.write_enable), 32'd0);
        end
        @(posedge clk); #1;
`ifdef KSA_SKIP_SELF_SWAP_EN
        check("self_next_addr", 32'(bus.address), 32'd1);
`else
        check("self_next_addr", 32'(bus.address), 32'd0);
`endif
        reset     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule : tb_ksa_swapper
`default_nettype wire
